// File: rtl/md_arb_pkg.sv
// rtl/md_arb_pkg.sv - shared constants and state encoding for the round-robin arbiter
package md_arb_pkg;

  localparam int N_REQ = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } arb_state_e;

  localparam logic [1:0] SEL_NONE = 2'b11;

endpackage

// File: rtl/md_rr_arbiter_if.sv
// rtl/md_rr_arbiter_if.sv - request/grant bundle between requesters and the arbiter
interface md_rr_arbiter_if #(
  parameter int HOLD_W = 4
);
  import md_arb_pkg::*;

  logic [N_REQ-1:0]  IN_REQ;
  logic [N_REQ-1:0]  OUT_GNT;
  logic [1:0]        OUT_SEL;
  logic              OUT_BUSY;
  logic [HOLD_W-1:0] OUT_HOLD_CNT;
  logic              OUT_PREEMPT;

  modport master (
    input  IN_REQ,
    output OUT_GNT, OUT_SEL, OUT_BUSY, OUT_HOLD_CNT, OUT_PREEMPT
  );

  modport slave (
    output IN_REQ,
    input  OUT_GNT, OUT_SEL, OUT_BUSY, OUT_HOLD_CNT, OUT_PREEMPT
  );

endinterface

// File: rtl/md_rr_pick.sv
// rtl/md_rr_pick.sv - rotating-priority picker: first set request after last, wrapping to last
module md_rr_pick
  import md_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [1:0]       last,
  output logic             valid,
  output logic [1:0]       idx
);

  logic [1:0] p0, p1, p2;

  always_comb begin
    p0 = 2'd0;
    p1 = 2'd1;
    p2 = 2'd2;
    case (last)
      2'd0: begin p0 = 2'd1; p1 = 2'd2; p2 = 2'd0; end
      2'd1: begin p0 = 2'd2; p1 = 2'd0; p2 = 2'd1; end
      default: begin p0 = 2'd0; p1 = 2'd1; p2 = 2'd2; end
    endcase
  end

  always_comb begin
    valid = |req;
    idx   = 2'd0;
    if (req[p0])      idx = p0;
    else if (req[p1]) idx = p1;
    else if (req[p2]) idx = p2;
  end

endmodule

// File: rtl/md_rr_arbiter.sv
// rtl/md_rr_arbiter.sv - three-way round-robin arbiter with bounded hold and one-cycle owner gap
module md_rr_arbiter
  import md_arb_pkg::*;
#(
  parameter int MAX_HOLD = 4,
  parameter int HOLD_W   = 4
) (
  input logic            clk,
  input logic            rst_n,
  md_rr_arbiter_if.master bus
);

  localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);

  arb_state_e        state_q, state_d;
  logic [1:0]        last_q, last_d;
  logic [1:0]        sel_q, sel_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic              pre_q, pre_d;
  logic              busy_q, busy_d;

  logic              pick_valid;
  logic [1:0]        pick_idx;
  logic              owner_req;
  logic              others_req;

  md_rr_pick u_pick (
    .req   (bus.IN_REQ),
    .last  (last_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign owner_req  = |(bus.IN_REQ & gnt_q);
  assign others_req = |(bus.IN_REQ & ~gnt_q);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    pre_d   = 1'b0;
    case (state_q)
      ST_IDLE, ST_GAP: begin
        if (pick_valid) begin
          state_d = ST_GRANT;
          last_d  = pick_idx;
          sel_d   = pick_idx;
          gnt_d   = 3'b001 << pick_idx;
          cnt_d   = HOLD_W'(1);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        // A release on the limit edge takes priority, so it never reports a preemption.
        if (!owner_req || (cnt_q == HOLD_LIMIT && others_req)) begin
          state_d = ST_GAP;
          sel_d   = SEL_NONE;
          gnt_d   = '0;
          cnt_d   = '0;
          pre_d   = owner_req;
        end else if (cnt_q != HOLD_LIMIT) begin
          cnt_d = cnt_q + HOLD_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        sel_d   = SEL_NONE;
        gnt_d   = '0;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      last_q  <= 2'd2;
      sel_q   <= SEL_NONE;
      gnt_q   <= '0;
      cnt_q   <= '0;
      pre_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.OUT_GNT      = gnt_q;
  assign bus.OUT_SEL      = sel_q;
  assign bus.OUT_BUSY     = busy_q;
  assign bus.OUT_HOLD_CNT = cnt_q;
  assign bus.OUT_PREEMPT  = pre_q;

endmodule

// File: tb/tb_md_rr_arbiter.sv
// tb/tb_md_rr_arbiter.sv - self-checking bench for md_rr_arbiter with two hold limits
module tb_md_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [2:0] req;
  int         n_checks;
  int         n_fail;

  md_rr_arbiter_if #(.HOLD_W(4)) bus0 ();
  md_rr_arbiter_if #(.HOLD_W(4)) bus1 ();

  assign bus0.IN_REQ = req;
  assign bus1.IN_REQ = req;

  md_rr_arbiter #(.MAX_HOLD(4), .HOLD_W(4)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  md_rr_arbiter #(.MAX_HOLD(1), .HOLD_W(4)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // mode: 0 idle, 1 granted, 2 gap
  typedef struct {
    int mode;
    int owner;
    int cnt;
    int last;
    bit pre;
  } m_t;

  m_t m0, m1;

  function automatic m_t m_reset();
    m_t s;
    s.mode = 0; s.owner = 0; s.cnt = 0; s.last = 2; s.pre = 1'b0;
    return s;
  endfunction

  function automatic int m_pick(input logic [2:0] r, input int last);
    for (int k = 1; k <= 3; k++) begin
      if (r[(last + k) % 3]) return (last + k) % 3;
    end
    return -1;
  endfunction

  function automatic m_t m_step(input m_t s, input logic [2:0] r, input int mh);
    m_t n;
    int p;
    n = s;
    n.pre = 1'b0;
    p = m_pick(r, s.last);
    if (s.mode == 1) begin
      if (r[s.owner] == 1'b0) begin
        n.mode = 2; n.cnt = 0;
      end else if (s.cnt == mh && (r & ~(3'b001 << s.owner)) != 3'b000) begin
        n.mode = 2; n.cnt = 0; n.pre = 1'b1;
      end else if (s.cnt < mh) begin
        n.cnt = s.cnt + 1;
      end
    end else if (p >= 0) begin
      n.mode = 1; n.owner = p; n.last = p; n.cnt = 1;
    end else begin
      n.mode = 0;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0 <= m_reset();
      m1 <= m_reset();
    end else begin
      m0 <= m_step(m0, req, 4);
      m1 <= m_step(m1, req, 1);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp(input string tag, input m_t s, input logic [2:0] g, input logic [1:0] sl,
                     input logic b, input logic [3:0] c, input logic p);
    logic [2:0] eg;
    logic [1:0] es;
    eg = (s.mode == 1) ? (3'b001 << s.owner) : 3'b000;
    es = (s.mode == 1) ? 2'(s.owner) : 2'b11;
    chk({tag, "_gnt"}, 32'(g), 32'(eg));
    chk({tag, "_sel"}, 32'(sl), 32'(es));
    chk({tag, "_busy"}, 32'(b), 32'(s.mode != 0));
    chk({tag, "_cnt"}, 32'(c), (s.mode == 1) ? 32'(s.cnt) : 32'd0);
    chk({tag, "_pre"}, 32'(p), 32'(s.pre));
  endtask

  always @(negedge clk) begin
    cmp("m0", m0, bus0.OUT_GNT, bus0.OUT_SEL, bus0.OUT_BUSY, bus0.OUT_HOLD_CNT, bus0.OUT_PREEMPT);
    cmp("m1", m1, bus1.OUT_GNT, bus1.OUT_SEL, bus1.OUT_BUSY, bus1.OUT_HOLD_CNT, bus1.OUT_PREEMPT);
  end

  task automatic chk_reset(input string tag);
    chk({tag, "_gnt"}, 32'(bus0.OUT_GNT), 32'h0);
    chk({tag, "_sel"}, 32'(bus0.OUT_SEL), 32'h3);
    chk({tag, "_busy"}, 32'(bus0.OUT_BUSY), 32'h0);
    chk({tag, "_cnt"}, 32'(bus0.OUT_HOLD_CNT), 32'h0);
    chk({tag, "_pre"}, 32'(bus0.OUT_PREEMPT), 32'h0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin
    logic [2:0] burst_exp [5];
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    req      = 3'b000;
    repeat (2) @(negedge clk);
    chk_reset("rst");
    rst_n = 1'b1;

    // Lone requester A: counter saturates, never preempted.
    req = 3'b001;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      chk("lone_gnt", 32'(bus0.OUT_GNT), 32'h1);
      chk("lone_cnt", 32'(bus0.OUT_HOLD_CNT), (c < 4) ? 32'(c) : 32'd4);
      chk("lone_pre", 32'(bus0.OUT_PREEMPT), 32'h0);
    end
    req = 3'b000;
    @(negedge clk);
    chk("lone_gap_gnt", 32'(bus0.OUT_GNT), 32'h0);
    chk("lone_gap_sel", 32'(bus0.OUT_SEL), 32'h3);
    chk("lone_gap_busy", 32'(bus0.OUT_BUSY), 32'h1);
    @(negedge clk);
    chk("lone_idle_busy", 32'(bus0.OUT_BUSY), 32'h0);

    // Reset while B owns the grant.
    req = 3'b010;
    @(negedge clk);
    chk("b_gnt", 32'(bus0.OUT_GNT), 32'h2);
    #2 rst_n = 1'b0;
    #1 chk_reset("midrst");
    req = 3'b110;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_gnt", 32'(bus0.OUT_GNT), 32'h2);
    chk("postrst_sel", 32'(bus0.OUT_SEL), 32'h1);
    req = 3'b000;
    repeat (3) @(negedge clk);

    // All requesting: last=B so rotation is D, A, B with 5-cycle slots.
    req = 3'b111;
    for (int c = 1; c <= 30; c++) begin
      int ph, k;
      @(negedge clk);
      ph = (c - 1) % 5;
      k  = (c - 1) / 5;
      if (ph < 4) begin
        chk("rot_gnt", 32'(bus0.OUT_GNT), 32'(3'b001 << ((2 + k) % 3)));
        chk("rot_cnt", 32'(bus0.OUT_HOLD_CNT), 32'(ph + 1));
        chk("rot_pre", 32'(bus0.OUT_PREEMPT), 32'h0);
      end else begin
        chk("rot_gap_gnt", 32'(bus0.OUT_GNT), 32'h0);
        chk("rot_gap_pre", 32'(bus0.OUT_PREEMPT), 32'h1);
      end
    end
    req = 3'b000;
    repeat (3) @(negedge clk);

    // A drops exactly at the hold limit with B waiting.
    req = 3'b001;
    @(negedge clk);
    chk("lim_gnt", 32'(bus0.OUT_GNT), 32'h1);
    req = 3'b011;
    repeat (3) @(negedge clk);
    chk("lim_cnt", 32'(bus0.OUT_HOLD_CNT), 32'h4);
    req = 3'b010;
    @(negedge clk);
    chk("lim_gap_gnt", 32'(bus0.OUT_GNT), 32'h0);
    chk("lim_gap_pre", 32'(bus0.OUT_PREEMPT), 32'h0);
    @(negedge clk);
    chk("lim_next_gnt", 32'(bus0.OUT_GNT), 32'h2);

    // D rises on the edge B releases.
    req = 3'b100;
    @(negedge clk);
    chk("late_gap_gnt", 32'(bus0.OUT_GNT), 32'h0);
    chk("late_gap_sel", 32'(bus0.OUT_SEL), 32'h3);
    @(negedge clk);
    chk("late_gnt", 32'(bus0.OUT_GNT), 32'h4);
    req = 3'b000;
    repeat (3) @(negedge clk);

    // MAX_HOLD=1 instance: single-cycle bursts between A and B.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req = 3'b011;
    burst_exp[0] = 3'b001; burst_exp[1] = 3'b000; burst_exp[2] = 3'b010;
    burst_exp[3] = 3'b000; burst_exp[4] = 3'b001;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("burst_gnt", 32'(bus1.OUT_GNT), 32'(burst_exp[c]));
      chk("burst_pre", 32'(bus1.OUT_PREEMPT), (burst_exp[c] == 3'b000) ? 32'h1 : 32'h0);
    end
    req = 3'b000;
    repeat (3) @(negedge clk);

    // Randomized traffic with occasional resets, checked by the model every cycle.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 249) != 0);
      if ($urandom_range(0, 3) == 0) req = 3'($urandom);
    end
    rst_n = 1'b1;
    req   = 3'b000;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/md_rr_arbiter.md
# md_rr_arbiter

Round-robin arbiter that shares one sequential datapath unit among three single-bit requesters (A, B, D). It sits in front of the shared `md_sequential_*` style unit, producing a registered one-hot grant plus owner index that drive the unit's input mux. A bounded hold time prevents starvation, and a mandatory one-cycle gap separates consecutive owners.

## Interface
- `MAX_HOLD`, default 4: maximum granted cycles before preemption when others wait; legal range 1..15.
- `HOLD_W`, default 4: width of the hold counter; must hold `MAX_HOLD`.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `IN_REQ` in 3: request levels. bit0=A, bit1=B, bit2=D.
- `OUT_GNT` out 3: registered one-hot grant, or 3'b000.
- `OUT_SEL` out 2: owner index 0..2; 2'b11 when no owner.
- `OUT_BUSY` out 1: high whenever state is not IDLE.
- `OUT_HOLD_CNT` out `HOLD_W`: cycles the current owner has held the grant.
- `OUT_PREEMPT` out 1: one-cycle pulse when a grant is revoked by `MAX_HOLD` expiry.

## Operation
- **States:**
  - IDLE: no grant.
  - GRANT: one owner.
  - GAP: one turnaround cycle, no grant.
- **Pointer `last`:** 2-bit index of the previous owner, reset to 2.
  - Search order is `last+1`, `last+2`, `last` (mod 3).
  - `last` updates to the new owner on every grant.
- **IDLE → GRANT:** at an edge where `IN_REQ != 0`.
  - The picked index becomes the owner.
  - `OUT_HOLD_CNT` := 1.
- **GRANT, normal release:** at an edge where the owner's `IN_REQ` bit is 0 → GAP, with `OUT_PREEMPT` = 0.
- **GRANT, preemption:** at an edge where `OUT_HOLD_CNT == MAX_HOLD`, the owner's bit is 1, and any other bit is 1 → GAP, with `OUT_PREEMPT` = 1 for the single GAP cycle.
- **GRANT, otherwise:** stay in GRANT.
  - `OUT_HOLD_CNT` increments and saturates at `MAX_HOLD`.
  - A lone requester may hold the grant indefinitely.
- **GAP:** at the next edge, go to GRANT with the picked owner if `IN_REQ != 0`, else go to IDLE.
- **Request bits:** non-owner bits are ignored during GRANT except in the preemption test. Requests are level-sensitive and are not latched.
- **Simultaneous events:**
  - If the owner drops its request on the same edge that `MAX_HOLD` is reached, it is a normal release with no `OUT_PREEMPT`.
  - If a request rises in the same edge the owner releases, it is ignored for that edge and considered at the GAP exit.
- **Reset (including mid-grant):** immediately forces state IDLE and `last` = 2.

## Timing
- **Reset values:**
  - `OUT_GNT` = 3'b000
  - `OUT_SEL` = 2'b11
  - `OUT_BUSY` = 0
  - `OUT_HOLD_CNT` = 0
  - `OUT_PREEMPT` = 0
- **Registering:** all outputs are registered and change only on the rising `clk` edge or on asynchronous reset assertion.
- **Grant latency:** a request sampled at edge k from IDLE makes `OUT_GNT` valid after edge k (1 cycle).
- **Owner turnaround:** the release edge is followed by exactly one GAP cycle, then the next owner. Minimum owner-to-owner spacing is 1 idle cycle.
- **`OUT_SEL` and `OUT_GNT`:** always mutually consistent.
- **`OUT_HOLD_CNT`:**
  - 0 in IDLE and GAP.
  - 1 in the first granted cycle.
- **Worst-case wait** for a pending requester: 2·(`MAX_HOLD`+1) cycles.

## Structure
- **Package `md_arb_pkg`:**
  - `N_REQ`=3.
  - State encodings IDLE=2'd0, GRANT=2'd1, GAP=2'd2.
  - `SEL_NONE`=2'b11.
- **Sub-module `md_rr_pick`:** combinational rotating-priority picker.
  - Inputs: `req[2:0]`, `last[1:0]`.
  - Outputs: `valid`, `idx[1:0]`.
  - Instantiated once. The FSM, counter and pointer live in `md_rr_arbiter`.

## Test plan
- **Reset mid-grant:** drive `rst_n`=0 while granted to B → all outputs go to reset values immediately. After release with `IN_REQ`=3'b110 → `OUT_GNT`=3'b010 and `OUT_SEL`=1 one cycle later, since `last`=2 gives B priority over D.
- **Lone requester:** A requests alone for 10 cycles → `OUT_GNT`=3'b001 with `OUT_HOLD_CNT` 1,2,3,4,4,… and no `OUT_PREEMPT`. When A drops → one GAP cycle (`OUT_GNT`=000, `OUT_SEL`=11, `OUT_BUSY`=1), then IDLE (`OUT_BUSY`=0).
- **All requests held** (`IN_REQ`=3'b111, `MAX_HOLD`=4) → owners rotate A→B→D→A. Each owner holds 4 cycles, followed by 1 GAP cycle with `OUT_PREEMPT`=1, giving a 15-cycle period.
- **Owner drops at the limit:** A drops its request at the edge where `OUT_HOLD_CNT`=4 while B is pending → GAP with `OUT_PREEMPT`=0, then `OUT_GNT`=3'b010.
- **Late request at release:** D rises in the same edge that owner B releases → GAP, then `OUT_GNT`=3'b100.
- **Single-cycle bursts** (`MAX_HOLD`=1, `IN_REQ`=3'b011 held) → `OUT_GNT` alternates 001,000,010,000,001, with `OUT_PREEMPT` high in every GAP cycle.
